mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 152 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Writeback stage feeding the register file: one registered write pulse per retiring instruction,
// loads wait in LOAD_WAIT for mem_rvalid (or a timeout), halts park the stage in HALTED until rst.
module mem_wb_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_dst,
    input  logic             in_regwrite,
    input  logic             in_is_load,
    input  logic             in_llb,
    input  logic             in_lhb,
    input  logic             in_halt,
    input  logic [15:0]      in_alu,
    input  logic             mem_rvalid,
    input  logic [15:0]      mem_rdata,
    output logic [3:0]       wb_dst,
    output logic             wb_we,
    output logic [15:0]      wb_data,
    output logic             wb_llb,
    output logic             wb_lhb,
    output logic             busy_valid,
    output logic [3:0]       busy_dst,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, HALTED} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ld_we_q, ld_we_d;
    logic             ld_halt_q, ld_halt_d;
    logic [3:0]       busy_dst_q, busy_dst_d;
    logic [3:0]       wb_dst_q, wb_dst_d;
    logic             wb_we_q, wb_we_d;
    logic [15:0]      wb_data_q, wb_data_d;
    logic             wb_llb_q, wb_llb_d;
    logic             wb_lhb_q, wb_lhb_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             ld_done;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        ld_we_d    = ld_we_q;
        ld_halt_d  = ld_halt_q;
        busy_dst_d = busy_dst_q;
        wb_dst_d   = wb_dst_q;
        wb_we_d    = 1'b0;
        wb_data_d  = wb_data_q;
        wb_llb_d   = 1'b0;
        wb_lhb_d   = 1'b0;
        err_d      = err_q;
        retired_d  = retired_q;
        ld_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        state_d    = LOAD_WAIT;
                        busy_dst_d = in_dst;
                        ld_we_d    = in_regwrite && (in_dst != 4'd0);
                        ld_halt_d  = in_halt;
                        tmo_d      = '0;
                    end else begin
                        wb_we_d   = in_regwrite && (in_dst != 4'd0);
                        wb_dst_d  = in_dst;
                        wb_data_d = (in_llb || in_lhb) ? {8'h00, in_alu[7:0]} : in_alu;
                        wb_llb_d  = wb_we_d && in_llb;
                        wb_lhb_d  = wb_we_d && in_lhb && !in_llb;
                        retired_d = retired_q + 1'b1;
                        if (in_halt) begin
                            state_d = HALTED;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (mem_rvalid) begin
                    wb_we_d   = ld_we_q;
                    wb_dst_d  = busy_dst_q;
                    wb_data_d = mem_rdata;
                    ld_done   = 1'b1;
                end else if ((TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1))) begin
                    // Abandoned load still counts as retired so software sees forward progress.
                    err_d   = 1'b1;
                    ld_done = 1'b1;
                end
                if (ld_done) begin
                    retired_d = retired_q + 1'b1;
                    tmo_d     = '0;
                    state_d   = ld_halt_q ? HALTED : IDLE;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            ld_we_q    <= 1'b0;
            ld_halt_q  <= 1'b0;
            busy_dst_q <= 4'd0;
            wb_dst_q   <= 4'd0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= 16'd0;
            wb_llb_q   <= 1'b0;
            wb_lhb_q   <= 1'b0;
            err_q      <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            ld_we_q    <= ld_we_d;
            ld_halt_q  <= ld_halt_d;
            busy_dst_q <= busy_dst_d;
            wb_dst_q   <= wb_dst_d;
            wb_we_q    <= wb_we_d;
            wb_data_q  <= wb_data_d;
            wb_llb_q   <= wb_llb_d;
            wb_lhb_q   <= wb_lhb_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy_valid = (state_q == LOAD_WAIT);
    assign busy_dst   = busy_dst_q;
    assign halted     = (state_q == HALTED);
    assign wb_dst     = wb_dst_q;
    assign wb_we      = wb_we_q;
    assign wb_data    = wb_data_q;
    assign wb_llb     = wb_llb_q;
    assign wb_lhb     = wb_lhb_q;
    assign err        = err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench: the driver pushes each expected register-file write, a negedge monitor pops on wb_we.
module tb_mem_wb_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_dst = 4'd0;
    logic        in_regwrite = 1'b0;
    logic        in_is_load = 1'b0;
    logic        in_llb = 1'b0;
    logic        in_lhb = 1'b0;
    logic        in_halt = 1'b0;
    logic [15:0] in_alu = 16'd0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [3:0]  wb_dst;
    logic        wb_we;
    logic [15:0] wb_data;
    logic        wb_llb;
    logic        wb_lhb;
    logic        busy_valid;
    logic [3:0]  busy_dst;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    mem_wb_stage #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst),
        .in_regwrite(in_regwrite), .in_is_load(in_is_load), .in_llb(in_llb),
        .in_lhb(in_lhb), .in_halt(in_halt), .in_alu(in_alu),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_dst(wb_dst), .wb_we(wb_we), .wb_data(wb_data), .wb_llb(wb_llb), .wb_lhb(wb_lhb),
        .busy_valid(busy_valid), .busy_dst(busy_dst), .halted(halted), .err(err),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
        logic        llb;
        logic        lhb;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ret_exp  = 0;
    bit  err_exp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wb_dst", {28'd0, wb_dst}, {28'd0, e.dst});
                    check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
                    check("wb_llb", {31'd0, wb_llb}, {31'd0, e.llb});
                    check("wb_lhb", {31'd0, wb_lhb}, {31'd0, e.lhb});
                end
            end else begin
                check("flags_without_we", {30'd0, wb_llb, wb_lhb}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        rst = 1'b1; in_valid = 1'b0; mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {wb_we, wb_llb, wb_lhb, busy_valid, halted, err, wb_dst, busy_dst},
              32'd0);
        check("rst_data_retired", {wb_data, retired}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        ret_exp = 0;
        err_exp = 1'b0;
    endtask

    // Issue one instruction; a load returns data on wait cycle dly (dly > TMO means it never returns).
    task automatic issue(input logic [3:0] dst, input bit rw, input bit ld, input bit llb,
                         input bit lhb, input bit halt, input logic [15:0] alu,
                         input int dly, input logic [15:0] rdata);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1; in_dst = dst; in_regwrite = rw; in_is_load = ld;
        in_llb = llb; in_lhb = lhb; in_halt = halt; in_alu = alu;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        if (!ld) begin
            ret_exp++;
            if (rw && dst != 0)
                exp_q.push_back('{dst, (llb || lhb) ? {8'h00, alu[7:0]} : alu, llb, lhb && !llb});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; mem_rvalid = 1'b0;
        if (ld) begin
            check("busy_valid_wait", {31'd0, busy_valid}, 32'd1);
            check("busy_dst", {28'd0, busy_dst}, {28'd0, dst});
            check("ready_in_wait", {31'd0, in_ready}, 32'd0);
            if (dly <= TMO) begin
                repeat (dly - 1) begin
                    @(posedge clk); #1;
                    check("busy_hold", {31'd0, busy_valid}, 32'd1);
                end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                ret_exp++;
                if (rw && dst != 0) exp_q.push_back('{dst, rdata, 1'b0, 1'b0});
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
            end else begin
                repeat (TMO - 1) begin
                    @(posedge clk); #1;
                    check("busy_hold_tmo", {31'd0, busy_valid}, 32'd1);
                end
                ret_exp++;
                err_exp = 1'b1;
                @(posedge clk); #1;
            end
            check("busy_clear", {31'd0, busy_valid}, 32'd0);
            check("ready_after_load", {31'd0, in_ready}, {31'd0, !halt});
        end
        check("err", {31'd0, err}, {31'd0, err_exp});
        check("halted", {31'd0, halted}, {31'd0, halt});
        check("retired", {16'd0, retired}, 32'(ret_exp & 16'hFFFF));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        do_reset();
        // Back-to-back non-loads.
        issue(4'd3, 1, 0, 0, 0, 0, 16'h1111, 0, 16'h0);
        issue(4'd5, 1, 0, 0, 0, 0, 16'h2222, 0, 16'h0);
        issue(4'd7, 1, 0, 0, 0, 0, 16'h3333, 0, 16'h0);
        // Load to r4 returning on the 4th wait cycle.
        issue(4'd4, 1, 1, 0, 0, 0, 16'h0, 4, 16'hBEEF);
        // LLB, LHB, both set.
        issue(4'd2, 1, 0, 1, 0, 0, 16'hAB5C, 0, 16'h0);
        issue(4'd2, 1, 0, 0, 1, 0, 16'h0012, 0, 16'h0);
        issue(4'd2, 1, 0, 1, 1, 0, 16'hFF77, 0, 16'h0);
        // r0 destination and a stray rvalid in IDLE.
        issue(4'd0, 1, 0, 0, 0, 0, 16'hDEAD, 0, 16'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hCAFE;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        check("stray_rvalid_busy", {31'd0, busy_valid}, 32'd0);
        // Minimum-latency load, then a timed-out load followed by a normal instruction.
        issue(4'd9, 1, 1, 0, 0, 0, 16'h0, 1, 16'h1234);
        issue(4'd6, 1, 1, 0, 0, 0, 16'h0, TMO + 1, 16'h0);
        issue(4'd8, 1, 0, 0, 0, 0, 16'h5A5A, 0, 16'h0);

        for (int i = 0; i < 150; i++) begin
            bit ld;
            ld = ($urandom_range(0, 3) == 0);
            issue(4'($urandom), 1'($urandom), ld,
                  ld ? 1'b0 : 1'($urandom), ld ? 1'b0 : 1'($urandom), 1'b0,
                  16'($urandom), int'($urandom_range(1, TMO + 2)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        // Halt with a write: halted on the writeback cycle, ready stays low.
        issue(4'd6, 1, 0, 0, 0, 1, 16'h4321, 0, 16'h0);
        in_valid = 1'b1; in_halt = 1'b0; in_is_load = 1'b0; in_dst = 4'd1;
        repeat (5) begin
            @(posedge clk); #1;
            check("halted_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;

        // Halt combined with a load.
        do_reset();
        issue(4'd11, 1, 1, 0, 0, 1, 16'h0, 2, 16'h7777);
        repeat (2) @(posedge clk);
        #1;
        check("halted_after_load", {31'd0, halted, in_ready}, 32'd2);

        // Reset in the middle of LOAD_WAIT drops the load.
        do_reset();
        in_valid = 1'b1; in_dst = 4'd12; in_regwrite = 1'b1; in_is_load = 1'b1;
        in_llb = 1'b0; in_lhb = 1'b0; in_halt = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_load_busy", {31'd0, busy_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_outputs", {wb_we, busy_valid, halted, err, busy_dst, wb_dst}, 32'd0);
        check("midrst_retired", {16'd0, retired}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
